fmc_adc_trigout_ts_fifo: RTL and testbench

//  Records trigger events (per-channel threshold triggers, external trigger) with a

---
 rtl/fmc_adc_trigout_pkg.sv | 38 +++
 rtl/fmc_adc_ts_sync_fifo.sv | 55 +++++
 rtl/fmc_adc_trigout_ts_fifo.sv | 131 +++++++++++++
 tb/tb_fmc_adc_trigout_ts_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fmc_adc_trigout_pkg.sv
// Shared definitions for the trigger-out timestamp FIFO: register map,
// bit positions and the layout of one recorded trigger entry.
package fmc_adc_trigout_pkg;

    // Word addresses (byte offset >> 2)
    localparam logic [2:0] ALT_TRIGOUT_STATUS      = 3'd0;
    localparam logic [2:0] ALT_TRIGOUT_CTRL        = 3'd1;
    localparam logic [2:0] ALT_TRIGOUT_TS_MASK_SEC = 3'd2;
    localparam logic [2:0] ALT_TRIGOUT_TS_SEC_LO   = 3'd3;
    localparam logic [2:0] ALT_TRIGOUT_TS_CYCLES   = 3'd4;

    localparam int ALT_TRIGOUT_TS_PRESENT_OFFSET = 0;
    localparam int ALT_TRIGOUT_OVERFLOW_OFFSET   = 1;
    localparam int ALT_TRIGOUT_CH1_ENABLE_OFFSET = 0;
    localparam int ALT_TRIGOUT_EXT_ENABLE_OFFSET = 8;
    localparam int ALT_TRIGOUT_CH1_MASK_OFFSET   = 16;
    localparam int ALT_TRIGOUT_EXT_MASK_OFFSET   = 24;
    localparam int ALT_TRIGOUT_WR_VALID_OFFSET   = 31;

    // hit[3:0] = channels 1..4, hit[4] = external trigger
    typedef struct packed {
        logic [4:0]  hit;
        logic        valid;
        logic [39:0] tai;
        logic [27:0] cycles;
    } t_trigout_entry;

    function automatic logic [31:0] f_mask_sec_word(input t_trigout_entry e);
        logic [31:0] w;
        w = '0;
        w[7:0]                               = e.tai[39:32];
        w[ALT_TRIGOUT_CH1_MASK_OFFSET +: 4]  = e.hit[3:0];
        w[ALT_TRIGOUT_EXT_MASK_OFFSET]       = e.hit[4];
        w[ALT_TRIGOUT_WR_VALID_OFFSET]       = e.valid;
        return w;
    endfunction

endpackage

// File: rtl/fmc_adc_ts_sync_fifo.sv
// Single-clock FIFO of trigger entries with first-word-fall-through output:
// dout always shows the oldest entry while the FIFO is not empty.
module fmc_adc_ts_sync_fifo
    import fmc_adc_trigout_pkg::*;
#(
    parameter int g_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  t_trigout_entry             din,
    input  logic                       pop,
    output t_trigout_entry             dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(g_DEPTH):0]   count
);

    localparam int AW = $clog2(g_DEPTH);

    t_trigout_entry mem [g_DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == (AW+1)'(g_DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop on an empty FIFO is ignored; a pop in the same cycle frees room for a push when full.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fmc_adc_trigout_ts_fifo.sv
// Trigger timestamp recorder: captures enabled trigger hits with WR time into a
// FIFO and exposes STATUS/CTRL/TS registers on a pipelined Wishbone slave.
module fmc_adc_trigout_ts_fifo
    import fmc_adc_trigout_pkg::*;
#(
    parameter int g_FIFO_DEPTH = 16
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    input  logic [3:0]  trig_ch_i,
    input  logic        trig_ext_i,
    input  logic [39:0] tm_tai_i,
    input  logic [27:0] tm_cycles_i,
    input  logic        tm_time_valid_i
);

    localparam int AW = $clog2(g_FIFO_DEPTH);

    logic           wb_strobe;
    logic           wb_rd;
    logic           wb_wr;
    logic [3:0]     ctrl_ch_en;
    logic           ctrl_ext_en;
    logic           overflow;
    logic [4:0]     hit_q;
    logic           valid_q;
    logic [39:0]    tai_q;
    logic [27:0]    cycles_q;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;
    t_trigout_entry push_entry;
    t_trigout_entry fifo_dout;
    t_trigout_entry head;
    logic [31:0]    rd_data;
    logic           unused_bits;

    // Handshake: every cycle with cyc&stb is a request (never stalled); it is answered
    // by exactly one ack on the next cycle, carrying read data, in request order.
    assign wb_strobe  = wb_cyc_i & wb_stb_i;
    assign wb_rd      = wb_strobe & ~wb_we_i;
    assign wb_wr      = wb_strobe &  wb_we_i;
    assign wb_stall_o = 1'b0;

    assign push       = |hit_q;
    assign push_entry = {hit_q, valid_q, tai_q, cycles_q};
    assign head       = fifo_empty ? '0 : fifo_dout;
    assign unused_bits = ^{wb_dat_i[31:9], wb_dat_i[7:4], fifo_count};

    fmc_adc_ts_sync_fifo #(
        .g_DEPTH (g_FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_n_i),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ALT_TRIGOUT_STATUS: begin
                rd_data[ALT_TRIGOUT_TS_PRESENT_OFFSET] = ~fifo_empty;
                rd_data[ALT_TRIGOUT_OVERFLOW_OFFSET]   = overflow;
            end
            ALT_TRIGOUT_CTRL: begin
                rd_data[ALT_TRIGOUT_CH1_ENABLE_OFFSET +: 4] = ctrl_ch_en;
                rd_data[ALT_TRIGOUT_EXT_ENABLE_OFFSET]      = ctrl_ext_en;
            end
            ALT_TRIGOUT_TS_MASK_SEC: rd_data       = f_mask_sec_word(head);
            ALT_TRIGOUT_TS_SEC_LO:   rd_data       = head.tai[31:0];
            ALT_TRIGOUT_TS_CYCLES:   rd_data[27:0] = head.cycles;
            default:                 rd_data       = '0;
        endcase
    end

    // Capture stage: hits and time are registered together so the entry is coherent.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            hit_q    <= '0;
            valid_q  <= 1'b0;
            tai_q    <= '0;
            cycles_q <= '0;
        end else begin
            hit_q    <= {trig_ext_i & ctrl_ext_en, trig_ch_i & ctrl_ch_en};
            valid_q  <= tm_time_valid_i;
            tai_q    <= tm_tai_i;
            cycles_q <= tm_cycles_i;
        end
    end

    // The pop is armed only if the TS_CYCLES read actually returned an entry.
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            pop         <= 1'b0;
            ctrl_ch_en  <= '0;
            ctrl_ext_en <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wb_ack_o <= wb_strobe;
            wb_dat_o <= wb_rd ? rd_data : '0;
            pop      <= wb_rd & (wb_adr_i == ALT_TRIGOUT_TS_CYCLES) & ~fifo_empty;
            if (wb_wr && wb_adr_i == ALT_TRIGOUT_CTRL) begin
                ctrl_ch_en  <= wb_dat_i[ALT_TRIGOUT_CH1_ENABLE_OFFSET +: 4];
                ctrl_ext_en <= wb_dat_i[ALT_TRIGOUT_EXT_ENABLE_OFFSET];
            end
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            else if (wb_wr && wb_adr_i == ALT_TRIGOUT_STATUS && wb_dat_i[ALT_TRIGOUT_OVERFLOW_OFFSET])
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fmc_adc_trigout_ts_fifo.sv
// Bench for the trigger timestamp FIFO: table-driven register/trigger vectors plus
// hand-written overflow, pop/push collision and reset sequences.
module tb_fmc_adc_trigout_ts_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [2:0]  wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_stall;
    logic [3:0]  trig_ch = '0;
    logic        trig_ext = 1'b0;
    logic [39:0] tm_tai = '0;
    logic [27:0] tm_cycles = '0;
    logic        tm_valid = 1'b0;

    fmc_adc_trigout_ts_fifo #(.g_FIFO_DEPTH(DEPTH)) dut (
        .sys_clk_i       (clk),
        .sys_rst_n_i     (rst_n),
        .wb_cyc_i        (wb_cyc),
        .wb_stb_i        (wb_stb),
        .wb_we_i         (wb_we),
        .wb_adr_i        (wb_adr),
        .wb_dat_i        (wb_dat_w),
        .wb_dat_o        (wb_dat_r),
        .wb_ack_o        (wb_ack),
        .wb_stall_o      (wb_stall),
        .trig_ch_i       (trig_ch),
        .trig_ext_i      (trig_ext),
        .tm_tai_i        (tm_tai),
        .tm_cycles_i     (tm_cycles),
        .tm_time_valid_i (tm_valid)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [32:0] exp_q[$];   // [32] = compare data (read), [31:0] = expected data
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_ack) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got ack with 0 accesses pending, expected none");
            end else begin
                logic [32:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (e[32]) check(n, wb_dat_r, e[31:0]);
            end
        end
    end

    // driver tasks
    task automatic wb_access(input logic [2:0] adr, input logic we, input logic [31:0] wdat,
                             input logic [31:0] exp, input string name);
        exp_q.push_back({~we, exp});
        name_q.push_back(name);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = wdat;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_dat_w = '0;
    endtask

    task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string name);
        wb_access(adr, 1'b0, 32'h0, exp, name);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] wdat);
        wb_access(adr, 1'b1, wdat, 32'h0, "write");
    endtask

    task automatic trig(input logic [3:0] ch, input logic ext, input logic valid,
                        input logic [39:0] tai, input logic [27:0] cyc);
        @(negedge clk);
        trig_ch = ch; trig_ext = ext; tm_valid = valid; tm_tai = tai; tm_cycles = cyc;
        @(negedge clk);
        trig_ch = '0; trig_ext = 1'b0;
    endtask

    // vector table
    typedef struct {
        int          kind;   // 0 read, 1 write, 2 trigger
        logic [2:0]  adr;
        logic [31:0] data;   // write data, or {valid, ext, ch} for a trigger
        logic [31:0] exp;
        logic [39:0] tai;
        logic [27:0] cyc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic void v_rd(input logic [2:0] a, input logic [31:0] e, input string n);
        vec_t v;
        v.kind = 0; v.adr = a; v.data = '0; v.exp = e; v.tai = '0; v.cyc = '0; v.name = n;
        vecs.push_back(v);
    endfunction

    function automatic void v_wr(input logic [2:0] a, input logic [31:0] d);
        vec_t v;
        v.kind = 1; v.adr = a; v.data = d; v.exp = '0; v.tai = '0; v.cyc = '0; v.name = "write";
        vecs.push_back(v);
    endfunction

    function automatic void v_tg(input logic [3:0] ch, input logic ext, input logic valid,
                                 input logic [39:0] tai, input logic [27:0] cyc);
        vec_t v;
        v.kind = 2; v.adr = '0; v.data = {26'h0, valid, ext, ch}; v.exp = '0;
        v.tai = tai; v.cyc = cyc; v.name = "trig";
        vecs.push_back(v);
    endfunction

    logic [27:0] model_q[$];
    logic [27:0] c;

    initial begin
        // after reset
        v_rd(3'd0, 32'h0, "rst_status");
        v_rd(3'd1, 32'h0, "rst_ctrl");
        v_rd(3'd4, 32'h0, "rst_cycles_empty");
        v_rd(3'd0, 32'h0, "rst_status_again");
        // basic capture with two channels
        v_wr(3'd1, 32'h0000_010F);
        v_rd(3'd1, 32'h0000_010F, "ctrl_rb");
        v_tg(4'b0101, 1'b0, 1'b1, 40'h32_0000_5a34, 28'h000_1000);
        v_rd(3'd2, 32'h8005_0032, "t2_mask_sec");
        v_rd(3'd3, 32'h0000_5a34, "t2_sec_lo");
        v_rd(3'd4, 32'h0000_1000, "t2_cycles");
        v_rd(3'd0, 32'h0, "t2_status_after_pop");
        // external trigger only
        v_tg(4'b0000, 1'b1, 1'b1, 40'hAB_1234_5678, 28'h0AB_CDEF);
        v_rd(3'd2, 32'h8100_00AB, "ext_mask_sec");
        v_rd(3'd3, 32'h1234_5678, "ext_sec_lo");
        v_rd(3'd4, 32'h00AB_CDEF, "ext_cycles");
        // all hits, all-ones time, invalid WR time
        v_tg(4'b1111, 1'b1, 1'b0, 40'hFF_FFFF_FFFF, 28'hFFF_FFFF);
        v_rd(3'd0, 32'h1, "all_status");
        v_rd(3'd2, 32'h010F_00FF, "all_mask_sec");
        v_rd(3'd3, 32'hFFFF_FFFF, "all_sec_lo");
        v_rd(3'd4, 32'h0FFF_FFFF, "all_cycles");
        // reserved addresses and CTRL read-zero bits
        v_rd(3'd5, 32'h0, "rsvd_rd5");
        v_wr(3'd7, 32'hFFFF_FFFF);
        v_rd(3'd7, 32'h0, "rsvd_rd7");
        v_wr(3'd1, 32'hFFFF_FFFF);
        v_rd(3'd1, 32'h0000_010F, "ctrl_unused_bits");
        // disabled sources, then two ch1 entries in order
        v_wr(3'd1, 32'h0000_0001);
        v_tg(4'b0010, 1'b1, 1'b1, 40'h0, 28'h5);
        v_rd(3'd0, 32'h0, "disabled_no_push");
        v_tg(4'b0001, 1'b0, 1'b0, 40'h1, 28'd10);
        v_tg(4'b0001, 1'b0, 1'b0, 40'h2, 28'd20);
        v_rd(3'd2, 32'h0001_0000, "t3_mask1");
        v_rd(3'd3, 32'h0000_0001, "t3_sec1");
        v_rd(3'd4, 32'd10,        "t3_cycles1");
        v_rd(3'd2, 32'h0001_0000, "t3_mask2");
        v_rd(3'd3, 32'h0000_0002, "t3_sec2");
        v_rd(3'd4, 32'd20,        "t3_cycles2");
        v_rd(3'd0, 32'h0, "t3_status_empty");

        repeat (3) @(negedge clk);
        check("rst_ack", {31'h0, wb_ack}, 32'h0);
        check("rst_dat", wb_dat_r, 32'h0);
        check("rst_stall", {31'h0, wb_stall}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                0: rd(vecs[i].adr, vecs[i].exp, vecs[i].name);
                1: wr(vecs[i].adr, vecs[i].data);
                default: trig(vecs[i].data[3:0], vecs[i].data[4], vecs[i].data[5],
                              vecs[i].tai, vecs[i].cyc);
            endcase
        end

        // overflow: depth+2 pulses keep the oldest depth entries
        for (int i = 0; i < DEPTH + 2; i++) trig(4'b0001, 1'b0, 1'b1, 40'h0, 28'(100 + i));
        rd(3'd0, 32'h3, "ovf_status");
        wr(3'd0, 32'h2);
        rd(3'd0, 32'h1, "ovf_cleared");
        for (int i = 0; i < DEPTH; i++) rd(3'd4, 32'(100 + i), "ovf_drain");
        rd(3'd0, 32'h0, "ovf_drained");

        // full FIFO, push landing on the pop ack cycle
        for (int i = 0; i < DEPTH; i++) begin
            c = 28'($urandom_range(0, 32'h0FFF_FFFF));
            model_q.push_back(c);
            trig(4'b0001, 1'b0, 1'b1, 40'h0, c);
        end
        rd(3'd0, 32'h1, "full_status");
        exp_q.push_back({1'b1, 4'h0, model_q.pop_front()});
        name_q.push_back("collide_cycles");
        model_q.push_back(28'hABC_0123);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 3'd4;
        trig_ch = 4'b0001; tm_cycles = 28'hABC_0123;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; trig_ch = '0;
        rd(3'd0, 32'h1, "collide_no_ovf");
        trig(4'b0001, 1'b0, 1'b1, 40'h0, 28'h555_5555);
        rd(3'd0, 32'h3, "collide_still_full");
        wr(3'd0, 32'h2);
        for (int i = 0; i < DEPTH; i++) rd(3'd4, {4'h0, model_q[i]}, "collide_drain");
        rd(3'd0, 32'h0, "collide_drained");

        // reset during a pending read with entries held
        for (int i = 0; i < 3; i++) trig(4'b0001, 1'b0, 1'b1, 40'h0, 28'(i + 1));
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 3'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check("midrst_no_ack", {31'h0, wb_ack}, 32'h0);
        check("midrst_dat", wb_dat_r, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(3'd0, 32'h0, "midrst_status");
        rd(3'd1, 32'h0, "midrst_ctrl");
        rd(3'd4, 32'h0, "midrst_cycles");

        repeat (3) @(negedge clk);
        check("pending_accesses", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
